// File: rtl/seg7_display_ctrl.sv
// Purpose: multi-digit active-low seven-segment controller; hex nibble decode or
//          sequential double-dabble binary-to-BCD for unsigned decimal display.
// Latency/backpressure: hex 1 cycle, decimal IN_W+2 cycles; load is dropped while busy.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            single-cycle request; captures value and dec_mode when accepted
//   value[IN_W]     binary value to show
//   dec_mode        0 = hex, 1 = unsigned decimal
//   busy            conversion in progress (loads ignored)
//   done            one-cycle pulse when seg updates
//   ovf             decimal value did not fit in DIGITS digits; valid with done, held
//   seg[7*DIGITS]   active-low segments, digit k at [7k+6:7k], bit 0 = a
//
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero blanking
// (digit 0 is always shown; the overflow dash pattern is never blanked).

module seg7_display_ctrl #(
   parameter int DIGITS = 3,
   parameter int IN_W   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [IN_W-1:0]       value,
   input  logic                  dec_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(IN_W + 1);

   typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

   state_t              state_q, state_d;
   logic [7*DIGITS-1:0] seg_q, seg_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                ovf_int_q, ovf_int_d;
   logic [IN_W-1:0]     shreg_q, shreg_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [BW-1:0]       bcd_adj;
   logic [BW+IN_W-1:0]  shifted;
   logic [BW-1:0]       val_ext;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0011000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Decode a packed nibble vector into segment patterns, most significant digit first
   // so the leading-zero flag can be carried downward.
   function automatic logic [7*DIGITS-1:0] render(input logic [BW-1:0] nib);
      logic [7*DIGITS-1:0] r;
`ifdef SEG7_LZ_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      r = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SEG7_LZ_BLANK_EN
         if (nib[4*k +: 4] != 4'd0 || k == 0) lead = 1'b0;
         r[7*k +: 7] = lead ? 7'b1111111 : glyph(nib[4*k +: 4]);
`else
         r[7*k +: 7] = glyph(nib[4*k +: 4]);
`endif
      end
      return r;
   endfunction

   always_comb begin
      val_ext = BW'(value);

      // Double-dabble correction: digits >= 5 get +3 before the shift.
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      shifted = {bcd_adj, shreg_q} << 1;

      state_d   = state_q;
      seg_d     = seg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      ovf_int_d = ovf_int_q;
      shreg_d   = shreg_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (load) begin
               if (dec_mode) begin
                  shreg_d   = value;
                  bcd_d     = '0;
                  cnt_d     = '0;
                  ovf_int_d = 1'b0;
                  busy_d    = 1'b1;
                  state_d   = CONV;
               end else begin
                  seg_d  = render(val_ext);
                  done_d = 1'b1;
                  ovf_d  = 1'b0;
               end
            end
         end
         CONV: begin
            bcd_d     = shifted[BW+IN_W-1 : IN_W];
            shreg_d   = shifted[IN_W-1:0];
            // A 1 leaving the top digit means the value needs more than DIGITS digits.
            ovf_int_d = ovf_int_q | bcd_adj[BW-1];
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CW'(IN_W - 1)) state_d = SHOW;
         end
         SHOW: begin
            seg_d   = ovf_int_q ? {DIGITS{7'b0111111}} : render(bcd_q);
            ovf_d   = ovf_int_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         seg_q     <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         ovf_int_q <= 1'b0;
         shreg_q   <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         ovf_int_q <= ovf_int_d;
         shreg_q   <= shreg_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign seg  = seg_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Purpose: self-checking bench for seg7_display_ctrl (DIGITS=3, IN_W=10).
// Latency: checks hex at cycle 1 and decimal at cycle IN_W+2 after load.
// Backpressure: checks that loads during busy/SHOW are dropped and rst wins over load.

module tb_seg7_display_ctrl;

   localparam int DIGITS = 3;
   localparam int IN_W   = 10;
   localparam int DASH   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load = 1'b0;
   logic [IN_W-1:0]   value = '0;
   logic              dec_mode = 1'b0;
   logic              busy, done, ovf;
   logic [7*DIGITS-1:0] seg;

   int n_checks = 0;
   int n_pass   = 0;

   seg7_display_ctrl #(.DIGITS(DIGITS), .IN_W(IN_W)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value),
      .dec_mode(dec_mode), .busy(busy), .done(done), .ovf(ovf), .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int dec;
      int d2, d1, d0;   // expected digit codes, 0..15, or DASH
      int exp_ovf;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [6:0] g7(input int c);
      case (c)
         0:  return 7'b1000000;  1:  return 7'b1111001;
         2:  return 7'b0100100;  3:  return 7'b0110000;
         4:  return 7'b0011001;  5:  return 7'b0010010;
         6:  return 7'b0000010;  7:  return 7'b1111000;
         8:  return 7'b0000000;  9:  return 7'b0011000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  15: return 7'b0001110;
         DASH: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [20:0] exp_seg(input int d2, input int d1, input int d0);
      logic [6:0] s2, s1, s0;
      s2 = g7(d2); s1 = g7(d1); s0 = g7(d0);
`ifdef SEG7_LZ_BLANK_EN
      if (d2 == 0) begin
         s2 = 7'b1111111;
         if (d1 == 0) s1 = 7'b1111111;
      end
`endif
      return {s2, s1, s0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat, bcnt;
      @(negedge clk);
      load = 1'b1; value = IN_W'(v.val); dec_mode = v.dec[0];
      @(negedge clk);
      load = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 50) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d latency", idx), lat, (v.dec != 0) ? IN_W + 2 : 1);
      check($sformatf("v%0d busy_cycles", idx), bcnt, (v.dec != 0) ? IN_W + 1 : 0);
      check($sformatf("v%0d seg", idx), 32'(seg), 32'(exp_seg(v.d2, v.d1, v.d0)));
      check($sformatf("v%0d ovf", idx), 32'(ovf), v.exp_ovf);
      check($sformatf("v%0d busy_at_done", idx), 32'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d done_1cyc", idx), 32'(done), 0);
   endtask

   initial begin
      int cyc, ndone, done_cyc;
      logic [20:0] seg_at_done;

      vecs[0]  = '{val: 'h2AF, dec: 0, d2: 2,  d1: 10,  d0: 15,  exp_ovf: 0};
      vecs[1]  = '{val: 'h000, dec: 0, d2: 0,  d1: 0,   d0: 0,   exp_ovf: 0};
      vecs[2]  = '{val: 'h3FF, dec: 0, d2: 3,  d1: 15,  d0: 15,  exp_ovf: 0};
      vecs[3]  = '{val: 'h005, dec: 0, d2: 0,  d1: 0,   d0: 5,   exp_ovf: 0};
      vecs[4]  = '{val: 999,   dec: 1, d2: 9,  d1: 9,   d0: 9,   exp_ovf: 0};
      vecs[5]  = '{val: 1000,  dec: 1, d2: DASH, d1: DASH, d0: DASH, exp_ovf: 1};
      vecs[6]  = '{val: 'h010, dec: 0, d2: 0,  d1: 1,   d0: 0,   exp_ovf: 0};
      vecs[7]  = '{val: 0,     dec: 1, d2: 0,  d1: 0,   d0: 0,   exp_ovf: 0};
      vecs[8]  = '{val: 7,     dec: 1, d2: 0,  d1: 0,   d0: 7,   exp_ovf: 0};
      vecs[9]  = '{val: 123,   dec: 1, d2: 1,  d1: 2,   d0: 3,   exp_ovf: 0};
      vecs[10] = '{val: 1023,  dec: 1, d2: DASH, d1: DASH, d0: DASH, exp_ovf: 1};
      vecs[11] = '{val: 500,   dec: 1, d2: 5,  d1: 0,   d0: 0,   exp_ovf: 0};
      vecs[12] = '{val: 'h0B0, dec: 0, d2: 0,  d1: 11,  d0: 0,   exp_ovf: 0};

      // Reset state after two cycles of rst.
      repeat (2) @(negedge clk);
      check("reset seg", 32'(seg), 32'h1FFFFF);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset ovf", 32'(ovf), 0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // Back-to-back hex loads on consecutive cycles.
      @(negedge clk);
      load = 1'b1; dec_mode = 1'b0; value = 10'h123;
      @(negedge clk);
      value = 10'h0C4;
      check("b2b done1", 32'(done), 1);
      check("b2b seg1", 32'(seg), 32'(exp_seg(1, 2, 3)));
      @(negedge clk);
      load = 1'b0;
      check("b2b done2", 32'(done), 1);
      check("b2b seg2", 32'(seg), 32'(exp_seg(0, 12, 4)));
      @(negedge clk);
      check("b2b done_low", 32'(done), 0);

      // Load of 5 during cycle 4 of a 123 conversion must be dropped.
      load = 1'b1; dec_mode = 1'b1; value = 10'd123;
      @(negedge clk);                 // cycle 1
      load = 1'b0;
      repeat (3) @(negedge clk);      // cycle 4
      load = 1'b1; dec_mode = 1'b0; value = 10'd5;
      cyc = 4; ndone = 0; done_cyc = -1; seg_at_done = '0;
      repeat (25) begin
         @(negedge clk);
         load = 1'b0;
         cyc++;
         if (done) begin
            ndone++;
            done_cyc = cyc;
            seg_at_done = seg;
         end
      end
      check("busyload ndone", ndone, 1);
      check("busyload done_cycle", done_cyc, IN_W + 2);
      check("busyload seg", 32'(seg_at_done), 32'(exp_seg(1, 2, 3)));

      // Reset in cycle 5 of a decimal conversion abandons it.
      load = 1'b1; dec_mode = 1'b1; value = 10'd999;
      @(negedge clk);                 // cycle 1
      load = 1'b0;
      repeat (4) @(negedge clk);      // cycle 5
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst seg", 32'(seg), 32'h1FFFFF);
      check("midrst busy", 32'(busy), 0);
      check("midrst done", 32'(done), 0);
      check("midrst ovf", 32'(ovf), 0);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst no_done", ndone, 0);
      run_vec('{val: 42, dec: 1, d2: 0, d1: 4, d0: 2, exp_ovf: 0}, 100);

      // rst and load together: rst wins, load dropped.
      @(negedge clk);
      rst = 1'b1; load = 1'b1; dec_mode = 1'b0; value = 10'h111;
      @(negedge clk);
      rst = 1'b0; load = 1'b0;
      check("rstload done", 32'(done), 0);
      check("rstload seg", 32'(seg), 32'h1FFFFF);
      @(negedge clk);
      check("rstload done_later", 32'(done), 0);
      check("rstload busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised multi-digit seven-segment display controller for the board-level DE-series labs. It accepts a binary value through a load/done handshake and shows it on DIGITS active-low seven-segment displays. Hex mode is a direct nibble decode. Decimal mode runs a sequential double-dabble binary-to-BCD conversion. It sits between datapath blocks (switch inputs, counters, ALU results) and the HEX display pins, and replaces per-design fixed-width hex decoders.

## Interface
Parameters:
- DIGITS, 3: number of displays driven; range 1–8.
- IN_W, 10: input value width; range 1 to 4*DIGITS, so hex mode never overflows.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- load  in  1  single-cycle request: capture value and mode.
- value  in  IN_W  binary value to display.
- dec_mode  in  1  0 = hexadecimal, 1 = unsigned decimal.
- busy  out  1  conversion in progress; load ignored while high.
- done  out  1  one-cycle pulse when seg updates.
- ovf  out  1  decimal value exceeded 10^DIGITS−1; valid with done, held until next done.
- seg  out  7*DIGITS  active-low segments; digit k at seg[7k+6:7k], bit 0 = a … bit 6 = g; digit 0 = least significant.

## Operation
- Glyphs (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111, dash=0111111.
- FSM states:
  - IDLE: load=1 and dec_mode=0 → seg loads the hex decode of the zero-extended value; go to IDLE. load=1 and dec_mode=1 → capture value into the shift register, clear the BCD register, reset the bit counter; go to CONV.
  - CONV: each cycle, add 3 to every BCD digit ≥5, then shift {bcd, shreg} left one bit. After IN_W shifts, go to SHOW.
  - SHOW: seg loads the decode of the BCD digits; go to IDLE.
- Decimal overflow: any 1 shifted out of the top BCD digit sets sticky ovf_int. In SHOW with ovf_int=1, every digit shows dash and ovf=1.
- Hex completion drives ovf=0.
- seg holds its last value between requests.
- load while busy=1 is ignored entirely; no queueing.
- load during the SHOW cycle is also ignored.
- dec_mode and value are sampled only on an accepted load.

## Timing
- Reset values: seg all 1s (blank), busy=0, done=0, ovf=0, FSM in IDLE.
- Hex mode: load accepted in cycle 0; seg and done=1 in cycle 1. Back-to-back loads are accepted every cycle.
- Decimal mode: load in cycle 0; busy=1 in cycles 1..IN_W+1; seg, ovf and done=1 in cycle IN_W+2; busy=0 in that cycle. The next load is accepted in cycle IN_W+2.
- done is high for exactly one cycle per accepted load.
- rst asserted mid-conversion abandons the conversion: next cycle all outputs take their reset values and no done is emitted.
- rst and load in the same cycle: rst wins and load is dropped.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking in both modes. Digits above the most significant non-zero digit show blank; digit 0 always shows. Blanking is applied in front of the seg register and adds no latency. Dash (overflow) display is not blanked.
- Undefined: all DIGITS digits are always shown, including leading zeros.

## Test plan
- Reset: assert rst 2 cycles → seg=all 1s, busy=0, done=0, ovf=0.
- Hex, DIGITS=3, IN_W=10: load value=0x2AF, dec_mode=0 → cycle 1: digits {2,A,F} = {0100100,0001000,0001110}, done pulse, ovf=0.
- Decimal: load value=999, dec_mode=1 → busy high 11 cycles; cycle 12: digits {9,9,9}, done, ovf=0. Then value=1000 → all dashes, ovf=1.
- Load during busy: second load with value=5 at cycle 4 of a conversion of 123 → shows 123; single done pulse.
- rst at cycle 5 of a decimal conversion → outputs return to reset values; no done pulse; a fresh load of 42 converts correctly.
- SEG7_LZ_BLANK_EN defined, decimal value=7 → digits {blank,blank,7}. Undefined → {0,0,7}.
